// File: rtl/cpu_control_unit.sv
// Microsequencer for the 8-bit accumulator CPU: fetch / decode / execute,
// driving the datapath strobe bus C1..C12 and handshaking with memory.
module cpu_control_unit #(
  parameter int OPC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_acc_neg,
  input  logic             i_mem_ready,
  output logic [15:0]      o_ctrl,
  output logic [1:0]       o_alu_op,
  output logic             o_halted,
  output logic             o_illegal,
  output logic             o_fetch
);

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F3, S_D, S_E1, S_E2, S_E3, S_E4, S_E5, S_HALT
  } state_t;

  localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(8'h00);
  localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(8'h01);
  localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(8'h02);
  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(8'h03);
  localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(8'h04);
  localparam logic [OPC_W-1:0] OP_JGEZ  = OPC_W'(8'h05);
  localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(8'h06);
  localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(8'h07);
  localparam logic [OPC_W-1:0] OP_CALL  = OPC_W'(8'h08);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    o_ctrl    = '0;
    o_alu_op  = 2'b00;
    o_halted  = 1'b0;
    o_illegal = 1'b0;
    o_fetch   = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_F1;
      S_HALT: begin
        o_halted = 1'b1;
        if (i_start) state_d = S_F1;
      end
      S_F1: begin
        o_ctrl[2] = 1'b1;
        o_fetch   = 1'b1;
        state_d   = S_F2;
      end
      S_F2: begin
        o_ctrl[7] = 1'b1;
        if (i_mem_ready) state_d = S_F3;
      end
      S_F3: begin
        o_ctrl[4] = 1'b1;
        state_d   = S_D;
      end
      S_D: begin
        // Opcode is latched so execute steps do not depend on IR staying put.
        op_d = i_opcode;
        case (i_opcode)
          OP_STORE, OP_LOAD, OP_ADD, OP_SUB,
          OP_JGEZ, OP_JMP, OP_CALL: state_d = S_E1;
          OP_HALT:                  state_d = S_HALT;
          default: begin
            o_illegal = (i_opcode != OP_NOP);
            state_d   = S_F1;
          end
        endcase
      end
      S_E1: begin
        state_d = S_E2;
        case (op_q)
          OP_STORE, OP_LOAD, OP_ADD, OP_SUB: o_ctrl[5] = 1'b1;
          OP_JMP:  o_ctrl[6] = 1'b1;
          OP_CALL: o_ctrl[1] = 1'b1;
          OP_JGEZ: begin
            // Taken only for a non-negative accumulator; else skip the jump.
            o_ctrl[6] = ~i_acc_neg;
            if (i_acc_neg) state_d = S_F1;
          end
          default: state_d = S_F1;
        endcase
      end
      S_E2: begin
        state_d = S_E3;
        case (op_q)
          OP_LOAD, OP_ADD, OP_SUB: begin
            o_ctrl[7] = 1'b1;
            if (!i_mem_ready) state_d = S_E2;
          end
          OP_STORE: o_ctrl[9] = 1'b1;
          OP_CALL:  o_ctrl[5] = 1'b1;
          OP_JMP, OP_JGEZ: begin
            o_ctrl[3] = 1'b1;
            state_d   = S_F1;
          end
          default: state_d = S_F1;
        endcase
      end
      S_E3: begin
        state_d = S_F1;
        case (op_q)
          OP_LOAD: o_ctrl[11] = 1'b1;
          OP_STORE: begin
            o_ctrl[8] = 1'b1;
            if (!i_mem_ready) state_d = S_E3;
          end
          OP_ADD, OP_SUB: begin
            o_ctrl[10] = 1'b1;
            state_d    = S_E4;
          end
          OP_CALL: begin
            o_ctrl[8] = 1'b1;
            state_d   = i_mem_ready ? S_E4 : S_E3;
          end
          default: state_d = S_F1;
        endcase
      end
      S_E4: begin
        state_d = S_F1;
        case (op_q)
          OP_ADD: begin
            o_ctrl[12] = 1'b1;
            o_alu_op   = 2'b01;
          end
          OP_SUB: begin
            o_ctrl[12] = 1'b1;
            o_alu_op   = 2'b10;
          end
          OP_CALL: begin
            o_ctrl[6] = 1'b1;
            state_d   = S_E5;
          end
          default: state_d = S_F1;
        endcase
      end
      S_E5: begin
        state_d = S_F1;
        if (op_q == OP_CALL) o_ctrl[3] = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: expected per-cycle strobe trace is generated
// from each instruction's step list, then replayed against the DUT.
module tb_cpu_control_unit;

  logic        i_clk, i_rst, i_start, i_acc_neg, i_mem_ready;
  logic [7:0]  i_opcode;
  logic [15:0] o_ctrl;
  logic [1:0]  o_alu_op;
  logic        o_halted, o_illegal, o_fetch;

  cpu_control_unit #(.OPC_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_opcode(i_opcode),
    .i_acc_neg(i_acc_neg), .i_mem_ready(i_mem_ready), .o_ctrl(o_ctrl),
    .o_alu_op(o_alu_op), .o_halted(o_halted), .o_illegal(o_illegal),
    .o_fetch(o_fetch)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [1:0]  alu;
    logic        ill, fetch, halt;
    logic        rdy, start;
    logic [7:0]  opc;
    logic        accn;
  } cyc_t;

  cyc_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  function automatic void push(input logic [15:0] c, input logic [1:0] a,
                               input logic il, input logic f, input logic h,
                               input logic rdy, input logic st,
                               input logic [7:0] op, input logic an);
    cyc_t r;
    r.ctrl = c; r.alu = a; r.ill = il; r.fetch = f; r.halt = h;
    r.rdy = rdy; r.start = st; r.opc = op; r.accn = an;
    q.push_back(r);
  endfunction

  // One step of the micro-program; a memory step stalls d cycles before ready.
  function automatic void step(input int strobe, input logic [1:0] a,
                               input logic f, input bit mem, input int d);
    logic [15:0] c;
    int n;
    c = 16'(1 << strobe);
    n = mem ? ((d < 0) ? int'($urandom_range(0, 3)) : d) : 0;
    for (int i = 0; i < n; i++) push(c, a, 1'b0, f, 1'b0, 1'b0, rb(), rbyte(), rb());
    push(c, a, 1'b0, f, 1'b0, mem ? 1'b1 : rb(), rb(), rbyte(), rb());
  endfunction

  function automatic void idle_start(input int n, input logic h);
    for (int i = 0; i < n; i++) push(16'h0, 2'b00, 1'b0, 1'b0, h, rb(), 1'b0, rbyte(), rb());
    push(16'h0, 2'b00, 1'b0, 1'b0, h, rb(), 1'b1, rbyte(), rb());
  endfunction

  function automatic void instr(input logic [7:0] op, input logic an,
                                input int fd, input int wd);
    step(2, 2'b00, 1'b1, 0, 0);
    step(7, 2'b00, 1'b0, 1, fd);
    step(4, 2'b00, 1'b0, 0, 0);
    push(16'h0, 2'b00, op > 8'h08, 1'b0, 1'b0, rb(), rb(), op, rb());
    case (op)
      8'h01: begin step(5, 2'b00, 0, 0, 0); step(9, 2'b00, 0, 0, 0); step(8, 2'b00, 0, 1, wd); end
      8'h02: begin step(5, 2'b00, 0, 0, 0); step(7, 2'b00, 0, 1, wd); step(11, 2'b00, 0, 0, 0); end
      8'h03, 8'h04: begin
        step(5, 2'b00, 0, 0, 0); step(7, 2'b00, 0, 1, wd); step(10, 2'b00, 0, 0, 0);
        step(12, (op == 8'h03) ? 2'b01 : 2'b10, 0, 0, 0);
      end
      8'h05: begin
        if (an) push(16'h0, 2'b00, 1'b0, 1'b0, 1'b0, rb(), rb(), rbyte(), 1'b1);
        else begin
          push(16'h0040, 2'b00, 1'b0, 1'b0, 1'b0, rb(), rb(), rbyte(), 1'b0);
          step(3, 2'b00, 0, 0, 0);
        end
      end
      8'h06: begin step(6, 2'b00, 0, 0, 0); step(3, 2'b00, 0, 0, 0); end
      8'h07: idle_start(int'($urandom_range(1, 3)), 1'b1);
      8'h08: begin
        step(1, 2'b00, 0, 0, 0); step(5, 2'b00, 0, 0, 0); step(8, 2'b00, 0, 1, wd);
        step(6, 2'b00, 0, 0, 0); step(3, 2'b00, 0, 0, 0);
      end
      default: ;
    endcase
  endfunction

  function automatic logic [20:0] outs();
    return {o_ctrl, o_alu_op, o_illegal, o_fetch, o_halted};
  endfunction

  // Called just after a rising edge; each record covers one clock cycle.
  task automatic run_all();
    cyc_t r;
    logic [20:0] exp;
    while (q.size() > 0) begin
      r = q.pop_front();
      #1;
      i_start = r.start; i_mem_ready = r.rdy; i_opcode = r.opc; i_acc_neg = r.accn;
      @(negedge i_clk);
      exp = {r.ctrl, r.alu, r.ill, r.fetch, r.halt};
      total++;
      assert (outs() === exp) else begin
        bad++;
        $error("FAIL cycle%0d outs observed=%h expected=%h", cyc, outs(), exp);
      end
      total++;
      assert ((o_ctrl[2] & o_ctrl[3]) === 1'b0) else begin
        bad++;
        $error("FAIL cycle%0d c2c3 observed=%h expected=0", cyc, o_ctrl);
      end
      cyc++;
      @(posedge i_clk);
    end
  endtask

  task automatic chk_zero(input string tag);
    total++;
    assert (outs() === 21'h0) else begin
      bad++;
      $error("FAIL %s observed=%h expected=0", tag, outs());
    end
  endtask

  initial begin
    logic [7:0] op;
    i_rst = 1'b1; i_start = 1'b0; i_opcode = 8'h00; i_acc_neg = 1'b0; i_mem_ready = 1'b0;
    #3 chk_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);

    idle_start(2, 1'b0);
    instr(8'h00, 1'b0, 2, 0);    // fetch with late memory
    instr(8'h03, 1'b0, 0, 0);    // ADD, ready immediate
    instr(8'h04, 1'b0, 1, 2);
    instr(8'h05, 1'b0, 0, 0);    // JGEZ taken
    instr(8'h05, 1'b1, 0, 0);    // JGEZ not taken
    instr(8'h08, 1'b0, 0, 3);    // CALL
    instr(8'h7F, 1'b0, 0, 0);    // undefined opcode
    instr(8'h01, 1'b0, 0, 2);
    instr(8'h02, 1'b0, 0, 1);
    instr(8'h07, 1'b0, 0, 0);    // HALT then resume
    run_all();

    for (int k = 0; k < 60; k++) begin
      op = 8'($urandom_range(0, 9));
      if (op == 8'h09) op = 8'($urandom_range(9, 255));
      instr(op, rb(), -1, -1);
    end
    run_all();

    // Abort mid-fetch: reset must clear strobes without waiting for a clock.
    step(2, 2'b00, 1'b1, 0, 0);
    push(16'h0080, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    run_all();
    #1 i_mem_ready = 1'b0; i_start = 1'b0;
    i_rst = 1'b1;
    #1 chk_zero("reset_midF2");
    @(negedge i_clk);
    chk_zero("reset_hold");
    i_rst = 1'b0;
    @(posedge i_clk);
    idle_start(1, 1'b0);
    instr(8'h06, 1'b0, 0, 0);
    instr(8'h03, 1'b0, -1, -1);
    run_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
